// File: rtl/reg_writeback.sv
// Register-file writeback unit: owns R0-R3, writes one or two results per transaction.
// Optional WB_BYPASS_EN forwards in-flight write data onto the read ports.
module reg_writeback #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   ir,
    input  logic          wb_valid,
    output logic          wb_ready,
    input  logic          wb_dual,
    input  logic [DW-1:0] res_x,
    input  logic [DW-1:0] res_y,
    output logic [DW-1:0] R0,
    output logic [DW-1:0] R1,
    output logic [DW-1:0] R2,
    output logic [DW-1:0] R3,
    input  logic [1:0]    rd_sel_x,
    input  logic [1:0]    rd_sel_y,
    output logic [DW-1:0] rd_x,
    output logic [DW-1:0] rd_y,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_X = 2'd1,
        WR_Y = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          dst_x_q, dst_x_d;
    logic [1:0]          dst_y_q, dst_y_d;
    logic [DW-1:0]       res_x_q, res_x_d;
    logic [DW-1:0]       res_y_q, res_y_d;
    logic                dual_q, dual_d;
    logic                nop_q, nop_d;
    logic                done_q, done_d;
    logic [3:0][DW-1:0]  regs_q, regs_d;

    logic                unused_ir;
    assign unused_ir = ^ir[7:0];

    always_comb begin
        state_d = state_q;
        dst_x_d = dst_x_q;
        dst_y_d = dst_y_q;
        res_x_d = res_x_q;
        res_y_d = res_y_q;
        dual_d  = dual_q;
        nop_d   = nop_q;
        regs_d  = regs_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wb_valid) begin
                    dst_x_d = ir[11:10];
                    dst_y_d = ir[9:8];
                    res_x_d = res_x;
                    res_y_d = res_y;
                    dual_d  = wb_dual;
                    nop_d   = (ir[15:12] == 4'h0);
                    state_d = WR_X;
                end
            end
            WR_X: begin
                if (!nop_q) begin
                    regs_d[dst_x_q] = res_x_q;
                end
                if (dual_q && !nop_q) begin
                    state_d = WR_Y;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            WR_Y: begin
                // Second write lands last, so it wins when dst_x == dst_y.
                regs_d[dst_y_q] = res_y_q;
                done_d          = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dst_x_q <= '0;
            dst_y_q <= '0;
            res_x_q <= '0;
            res_y_q <= '0;
            dual_q  <= 1'b0;
            nop_q   <= 1'b0;
            done_q  <= 1'b0;
            regs_q  <= '0;
        end else begin
            state_q <= state_d;
            dst_x_q <= dst_x_d;
            dst_y_q <= dst_y_d;
            res_x_q <= res_x_d;
            res_y_q <= res_y_d;
            dual_q  <= dual_d;
            nop_q   <= nop_d;
            done_q  <= done_d;
            regs_q  <= regs_d;
        end
    end

    always_comb begin
        rd_x = regs_q[rd_sel_x];
        rd_y = regs_q[rd_sel_y];
`ifdef WB_BYPASS_EN
        // Only the write happening this cycle is forwarded.
        if (state_q == WR_X && !nop_q && rd_sel_x == dst_x_q) begin
            rd_x = res_x_q;
        end else if (state_q == WR_Y && rd_sel_x == dst_y_q) begin
            rd_x = res_y_q;
        end
        if (state_q == WR_X && !nop_q && rd_sel_y == dst_x_q) begin
            rd_y = res_x_q;
        end else if (state_q == WR_Y && rd_sel_y == dst_y_q) begin
            rd_y = res_y_q;
        end
`endif
    end

    assign R0       = regs_q[0];
    assign R1       = regs_q[1];
    assign R2       = regs_q[2];
    assign R3       = regs_q[3];
    assign busy     = (state_q != IDLE);
    assign wb_ready = (state_q == IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback.
module tb_reg_writeback;

    logic        clk;
    logic        rst_n;
    logic [15:0] ir;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_dual;
    logic [7:0]  res_x;
    logic [7:0]  res_y;
    logic [7:0]  R0, R1, R2, R3;
    logic [1:0]  rd_sel_x;
    logic [1:0]  rd_sel_y;
    logic [7:0]  rd_x;
    logic [7:0]  rd_y;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    reg_writeback #(.DW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ir       (ir),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_dual  (wb_dual),
        .res_x    (res_x),
        .res_y    (res_y),
        .R0       (R0),
        .R1       (R1),
        .R2       (R2),
        .R3       (R3),
        .rd_sel_x (rd_sel_x),
        .rd_sel_y (rd_sel_y),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag, input logic [7:0] e0,
                              input logic [7:0] e1, input logic [7:0] e2,
                              input logic [7:0] e3);
        check({tag, "_r0"}, 32'(R0), 32'(e0));
        check({tag, "_r1"}, 32'(R1), 32'(e1));
        check({tag, "_r2"}, 32'(R2), 32'(e2));
        check({tag, "_r3"}, 32'(R3), 32'(e3));
    endtask

    task automatic offer(input logic [15:0] i, input logic d,
                         input logic [7:0] x, input logic [7:0] y);
        ir       = i;
        wb_dual  = d;
        res_x    = x;
        res_y    = y;
        wb_valid = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        ir       = '0;
        wb_valid = 1'b0;
        wb_dual  = 1'b0;
        res_x    = '0;
        res_y    = '0;
        rd_sel_x = 2'd0;
        rd_sel_y = 2'd0;
        #12;
        check_regs("rst", 8'h00, 8'h00, 8'h00, 8'h00);
        check("rst_ready", 32'(wb_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // single write R2 <= A5
        @(negedge clk);
        rd_sel_x = 2'd2;
        rd_sel_y = 2'd2;
        offer(16'h1800, 1'b0, 8'hA5, 8'h00);
        step();
        wb_valid = 1'b0;
        check("s_busy", 32'(busy), 32'd1);
        check("s_ready", 32'(wb_ready), 32'd0);
        check("s_done0", 32'(done), 32'd0);
        check("s_r2_old", 32'(R2), 32'h00);
`ifdef WB_BYPASS_EN
        check("s_byp_x", 32'(rd_x), 32'hA5);
        check("s_byp_y", 32'(rd_y), 32'hA5);
`else
        check("s_nobyp_x", 32'(rd_x), 32'h00);
        check("s_nobyp_y", 32'(rd_y), 32'h00);
`endif
        step();
        check_regs("s", 8'h00, 8'h00, 8'hA5, 8'h00);
        check("s_done1", 32'(done), 32'd1);
        check("s_busy1", 32'(busy), 32'd0);
        check("s_ready1", 32'(wb_ready), 32'd1);
        check("s_rdx", 32'(rd_x), 32'hA5);
        step();
        check("s_done2", 32'(done), 32'd0);

        // dual R0 <= 11, R1 <= 22
        rd_sel_x = 2'd0;
        rd_sel_y = 2'd1;
        offer(16'h2100, 1'b1, 8'h11, 8'h22);
        step();
        wb_valid = 1'b0;
        check("d_ready0", 32'(wb_ready), 32'd0);
        step();
        check("d_r0", 32'(R0), 32'h11);
        check("d_r1_old", 32'(R1), 32'h00);
        check("d_ready1", 32'(wb_ready), 32'd0);
        check("d_done1", 32'(done), 32'd0);
        check("d_busy1", 32'(busy), 32'd1);
`ifdef WB_BYPASS_EN
        check("d_byp_y", 32'(rd_y), 32'h22);
`else
        check("d_nobyp_y", 32'(rd_y), 32'h00);
`endif
        step();
        check_regs("d", 8'h11, 8'h22, 8'hA5, 8'h00);
        check("d_done2", 32'(done), 32'd1);
        check("d_ready2", 32'(wb_ready), 32'd1);
        check("d_rdx", 32'(rd_x), 32'h11);
        check("d_rdy", 32'(rd_y), 32'h22);
        step();
        check("d_done3", 32'(done), 32'd0);

        // dual to same register: second write wins
        offer(16'h2F00, 1'b1, 8'h01, 8'h02);
        step();
        wb_valid = 1'b0;
        step();
        check("same_r3_x", 32'(R3), 32'h01);
        step();
        check("same_r3_y", 32'(R3), 32'h02);
        check("same_done", 32'(done), 32'd1);
        step();

        // NOP targeting R3: no change, single-cycle, done pulses
        offer(16'h0C00, 1'b1, 8'hFF, 8'hEE);
        step();
        wb_valid = 1'b0;
        check("nop_busy", 32'(busy), 32'd1);
        step();
        check_regs("nop", 8'h11, 8'h22, 8'hA5, 8'h02);
        check("nop_done", 32'(done), 32'd1);
        check("nop_ready", 32'(wb_ready), 32'd1);
        step();
        check("nop_done2", 32'(done), 32'd0);

        // valid held; res_x changes while busy
        offer(16'h1400, 1'b0, 8'h33, 8'h00);
        step();
        res_x = 8'h44;
        check("hold_busy", 32'(busy), 32'd1);
        step();
        check("hold_r1a", 32'(R1), 32'h33);
        check("hold_done", 32'(done), 32'd1);
        check("hold_ready", 32'(wb_ready), 32'd1);
        step();
        wb_valid = 1'b0;
        check("hold_busy2", 32'(busy), 32'd1);
        check("hold_done_gap", 32'(done), 32'd0);
        step();
        check("hold_r1b", 32'(R1), 32'h44);
        check("hold_done2", 32'(done), 32'd1);
        step();

        // reset during WR_Y of a dual
        offer(16'h1100, 1'b1, 8'h77, 8'h88);
        step();
        wb_valid = 1'b0;
        step();
        check("rs_r0", 32'(R0), 32'h77);
        check("rs_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_regs("rs", 8'h00, 8'h00, 8'h00, 8'h00);
        check("rs_busy0", 32'(busy), 32'd0);
        check("rs_ready", 32'(wb_ready), 32'd1);
        check("rs_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rs_done_after", 32'(done), 32'd0);
        check("rs_r1_after", 32'(R1), 32'h00);

        // read-port forwarding of R2 <= 5A
        rd_sel_x = 2'd2;
        offer(16'h3800, 1'b0, 8'h5A, 8'h00);
        step();
        wb_valid = 1'b0;
`ifdef WB_BYPASS_EN
        check("byp_rdx", 32'(rd_x), 32'h5A);
`else
        check("nobyp_rdx", 32'(rd_x), 32'h00);
`endif
        step();
        check("byp_rdx_after", 32'(rd_x), 32'h5A);
        check("byp_r2", 32'(R2), 32'h5A);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
